// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int unsigned WORD_W           = 32;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Fetch FSM encoding (kept as plain constants for legacy tools).
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  // One prefetch buffer entry: instruction word plus the PC it was fetched from.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response and decode-side handshake bundle.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic              imem_req_valid;
  logic [WORD_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [WORD_W-1:0] imem_rsp_data;
  logic              instr_valid;
  logic [WORD_W-1:0] instr_out;
  logic [WORD_W-1:0] instr_pc;
  logic              instr_ready;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );

  // Memory / decode side.
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous prefetch FIFO with push/pop/flush; head reads as zero when empty.
module instr_fetch_unit_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              pop_en, push_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign pop_en  = pop && !empty;
  // A full FIFO may still accept when the head leaves in the same cycle.
  assign push_en = push && (!full || pop_en);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    end
  end

  // Storage array; contents need no reset since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (push_en && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  // Overflow means the upstream credit logic is broken.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop_en && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem request issue with credit control, in-order response
// tracking, stale-response dropping on redirect, prefetch buffer toward decode.
// Optional build macro IFETCH_STALL_CNT_EN adds stall_cnt / flush_cnt outputs.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  instr_fetch_unit_if.master bus
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [OW-1:0]     drop_q, drop_d;

  logic              credit_ok, req_valid, req_fire, rsp;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  fetch_entry_t      fifo_wdata, fifo_rdata;

  // Request issue: only in RUN with buffer credit and never during a redirect.
  always_comb begin
    credit_ok = ((32'(fifo_count) + 32'(outst_q)) < FIFO_DEPTH) &&
                (32'(outst_q) < MAX_OUTST) && !fifo_full;
    req_valid = (state_q == StRun) && credit_ok && !redirect_valid;
    req_fire  = req_valid && bus.imem_req_ready;
    rsp       = bus.imem_rsp_valid;
    // Responses are in order, so a surviving response always belongs to rsp_pc_q.
    fifo_push = rsp && !redirect_valid && (drop_q == '0);
    fifo_pop  = !fifo_empty && bus.instr_ready && !redirect_valid;
    fifo_wdata = '{data: bus.imem_rsp_data, pc: rsp_pc_q};
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = !fifo_empty;
  assign bus.instr_out      = fifo_rdata.data;
  assign bus.instr_pc       = fifo_rdata.pc;

  // Next-state for PC, response PC, in-flight and drop counters, FSM.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    outst_d  = outst_q + OW'(req_fire) - OW'(rsp);
    drop_d   = drop_q;
    state_d  = state_q;

    if (redirect_valid) begin
      pc_d     = word_align(redirect_pc);
      rsp_pc_d = word_align(redirect_pc);
      // Everything still in flight is stale; a response arriving now is dropped directly.
      drop_d   = outst_q - OW'(rsp);
    end else begin
      if (req_fire)          pc_d     = pc_q + WORD_W'(INSTR_BYTES);
      if (fifo_push)         rsp_pc_d = rsp_pc_q + WORD_W'(INSTR_BYTES);
      if (rsp && drop_q != '0) drop_d = drop_q - 1'b1;
    end

    unique case (state_q)
      StIdle:  if (fetch_en) state_d = StRun;
      StRun:   if (!fetch_en) state_d = StIdle;
      StFlush: if (drop_q == '0) state_d = fetch_en ? StRun : StIdle;
      default: state_d = StIdle;
    endcase

    if (redirect_valid) begin
      state_d = (drop_d != '0) ? StFlush : (fetch_en ? StRun : StIdle);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
    end
  end

  instr_fetch_unit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating counters: starved-decode cycles while running, and redirects taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state_q == StRun && fifo_empty && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect_valid && flush_cnt_q != '1)                 flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order memory model of programmable latency.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_3000),
    .FIFO_DEPTH (4),
    .MAX_OUTST  (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (ifc)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  int          cyc = 0;
  int          pops = 0;
  int          fires = 0;
  logic [31:0] exp_pc = 32'h0000_3000;
  logic [31:0] exp_req = 32'h0000_3000;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] popped[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory model: in-order, returns ~addr after mem_lat cycles.
  initial begin : mem_model
    logic        fire, took;
    logic [31:0] faddr;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      fire  = ifc.imem_req_valid && ifc.imem_req_ready;
      faddr = ifc.imem_req_addr;
      took  = ifc.imem_rsp_valid;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        q_addr.delete();
        q_due.delete();
      end else begin
        if (took && q_addr.size() > 0) begin
          void'(q_addr.pop_front());
          void'(q_due.pop_front());
        end
        if (fire) begin
          q_addr.push_back(faddr);
          q_due.push_back(cyc + mem_lat - 1);
        end
      end
      #1;
      if (rst_n && q_addr.size() > 0 && q_due[0] <= cyc) begin
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = ~q_addr[0];
      end else begin
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_data  = '0;
      end
    end
  end

  // Scoreboard on accepted requests and consumed instructions.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && !redirect_valid) begin
        if (ifc.instr_valid && ifc.instr_ready) begin
          check("pop_pc", ifc.instr_pc, exp_pc);
          check("pop_data", ifc.instr_out, ~exp_pc);
          popped.push_back(ifc.instr_pc);
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
        if (ifc.imem_req_valid && ifc.imem_req_ready) begin
          check("req_addr", ifc.imem_req_addr, exp_req);
          exp_req = exp_req + 32'd4;
          fires++;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    int gaps;
    bit found;

    rst_n              = 1'b0;
    fetch_en           = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    ifc.imem_req_ready = 1'b1;
    ifc.instr_ready    = 1'b1;
    step(3);

    // Reset state
    check("rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    check("rst_req_addr", ifc.imem_req_addr, 32'h0000_3000);
    check("rst_instr_valid", 32'(ifc.instr_valid), 32'd0);
    check("rst_instr_out", ifc.instr_out, 32'd0);
    check("rst_instr_pc", ifc.instr_pc, 32'd0);
`ifdef IFETCH_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif

    // 1: streaming with 1-cycle memory, no gaps once the pipe is full
    rst_n    = 1'b1;
    fetch_en = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ifc.instr_valid) found = 1'b1;
    end
    check("t1_first_valid", 32'(found), 32'd1);
    gaps = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!ifc.instr_valid) gaps++;
    end
    check("t1_gaps", 32'(gaps), 32'd0);
    check("t1_first_pc", popped[0], 32'h0000_3000);

    // 2: decode stalls; buffer fills to depth and issue stops
    step(1);
    ifc.instr_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("t2_req_idle", 32'(ifc.imem_req_valid), 32'd0);
    check("t2_valid_held", 32'(ifc.instr_valid), 32'd1);
    step(1);
    base            = pops;
    fetch_en        = 1'b0;
    ifc.instr_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ifc.instr_valid) break;
    end
    check("t2_words", 32'(pops - base), 32'd4);

    // 3: 3-cycle memory, redirect with two fetches in flight
    step(1);
    mem_lat  = 3;
    fetch_en = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #2;
      if (q_addr.size() == 2) found = 1'b1;
    end
    check("t3_two_inflight", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4002;
    exp_pc         = 32'h0000_4000;
    exp_req        = 32'h0000_4000;
    popped.delete();
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_flushed", 32'(ifc.instr_valid), 32'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (popped.size() > 0) break;
    end
    check("t3_got_word", 32'(popped.size() > 0), 32'd1);
    if (popped.size() > 0) check("t3_first_pc", popped[0], 32'h0000_4000);

    // 4: redirect to the top of the address space, fetch wraps to zero
    step(1);
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    exp_pc         = 32'hFFFF_FFFC;
    exp_req        = 32'hFFFF_FFFC;
    popped.delete();
    step(1);
    redirect_valid = 1'b0;
    step(12);
    check("t4_count", 32'(popped.size() >= 2), 32'd1);
    if (popped.size() >= 2) begin
      check("t4_top", popped[0], 32'hFFFF_FFFC);
      check("t4_wrap", popped[1], 32'h0000_0000);
    end
`ifdef IFETCH_STALL_CNT_EN
    check("t4_flush_cnt", 32'(flush_cnt), 32'd2);
`endif

    // 5: memory back-pressure holds the request; fetch_en=0 drains
    ifc.imem_req_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_valid", 32'(ifc.imem_req_valid), 32'd1);
      check("t5_hold_addr", ifc.imem_req_addr, exp_req);
    end
    step(1);
    fetch_en           = 1'b0;
    ifc.imem_req_ready = 1'b1;
    step(2);
    base = fires;
    step(10);
    check("t5_no_new_req", 32'(fires - base), 32'd0);
    @(negedge clk);
    check("t5_drained_fifo", 32'(ifc.instr_valid), 32'd0);
    check("t5_drained_mem", 32'(q_addr.size()), 32'd0);

    // 6: reset in the middle of a burst
    step(1);
    fetch_en = 1'b1;
    step(6);
    rst_n = 1'b0;
    #1;
    check("t6_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    check("t6_req_addr", ifc.imem_req_addr, 32'h0000_3000);
    check("t6_instr_valid", 32'(ifc.instr_valid), 32'd0);
    check("t6_instr_out", ifc.instr_out, 32'd0);
    check("t6_instr_pc", ifc.instr_pc, 32'd0);
`ifdef IFETCH_STALL_CNT_EN
    check("t6_stall_cnt", stall_cnt, 32'd0);
    check("t6_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    step(3);
    exp_pc  = 32'h0000_3000;
    exp_req = 32'h0000_3000;
    popped.delete();
    rst_n = 1'b1;
    step(10);
    check("t6_restart_cnt", 32'(popped.size() > 0), 32'd1);
    if (popped.size() > 0) check("t6_restart_pc", popped[0], 32'h0000_3000);

    fetch_en = 1'b0;
    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
